// File: rtl/butterfly_pkg.sv
// Shared constants and helpers for the radix-2 butterfly datapath.
// Optional build macro BUTTERFLY_ROUND_EN selects round-half-up shifts.
package butterfly_pkg;

  localparam int W_DEF  = 16;
  localparam int TW_DEF = 16;

  // Largest positive value of a w-bit two's complement word.
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  // Most negative value of a w-bit two's complement word.
  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  // Twiddles are Q1.(tw-1): products are renormalised by tw-1 bits.
  function automatic int q_shift(input int tw);
    return tw - 1;
  endfunction

  // Half an LSB of the renormalised product, added before the shift when rounding.
  function automatic longint round_const(input int tw);
    return longint'(1) << (tw - 2);
  endfunction

endpackage

// File: rtl/butterfly_r2_pipe_if.sv
// Beat interface of the butterfly: input beat, output beat and overflow flag.
// Data components are two's complement; widths follow W and TW.
interface butterfly_r2_pipe_if
  import butterfly_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int TW = TW_DEF
);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  ar;
  logic signed [W-1:0]  ai;
  logic signed [W-1:0]  br;
  logic signed [W-1:0]  bi;
  logic signed [TW-1:0] wr;
  logic signed [TW-1:0] wi;
  logic                 scale;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [W-1:0]  y0r;
  logic signed [W-1:0]  y0i;
  logic signed [W-1:0]  y1r;
  logic signed [W-1:0]  y1i;

  logic                 ovf;
  logic                 ovf_clr;

  // Producer/consumer side: drives operands, accepts results.
  modport master (
    output in_valid, ar, ai, br, bi, wr, wi, scale, out_ready, ovf_clr,
    input  in_ready, out_valid, y0r, y0i, y1r, y1i, ovf
  );

  // Butterfly side.
  modport slave (
    input  in_valid, ar, ai, br, bi, wr, wi, scale, out_ready, ovf_clr,
    output in_ready, out_valid, y0r, y0i, y1r, y1i, ovf
  );

endinterface

// File: rtl/cmplx_mult.sv
// Registered complex product p = b * w, renormalised from Q1.(TW-1) to W+2 bits.
// With BUTTERFLY_ROUND_EN the renormalising shift rounds half-up, else floors.
module cmplx_mult
  import butterfly_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int TW = TW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [W-1:0]  br,
  input  logic signed [W-1:0]  bi,
  input  logic signed [TW-1:0] wr,
  input  logic signed [TW-1:0] wi,
  output logic signed [W+1:0]  pr,
  output logic signed [W+1:0]  pi
);

  localparam int PW = W + TW + 1;
  localparam int SH = q_shift(TW);

  logic signed [PW-1:0] m_rr;
  logic signed [PW-1:0] m_ii;
  logic signed [PW-1:0] m_ri;
  logic signed [PW-1:0] m_ir;
  logic signed [PW-1:0] re_acc;
  logic signed [PW-1:0] im_acc;
  logic                 unused_lo;

  // Full-precision partial products and their sums (with optional half-LSB bias).
  always_comb begin
    m_rr   = PW'(br) * PW'(wr);
    m_ii   = PW'(bi) * PW'(wi);
    m_ri   = PW'(br) * PW'(wi);
    m_ir   = PW'(bi) * PW'(wr);
`ifdef BUTTERFLY_ROUND_EN
    re_acc = m_rr - m_ii + PW'(round_const(TW));
    im_acc = m_ri + m_ir + PW'(round_const(TW));
`else
    re_acc = m_rr - m_ii;
    im_acc = m_ri + m_ir;
`endif
  end

  // Fraction bits dropped by the shift.
  assign unused_lo = ^{re_acc[SH-1:0], im_acc[SH-1:0]};

  // Product register; taking the top W+2 bits is an arithmetic shift right by SH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pr <= '0;
      pi <= '0;
    end else if (en) begin
      pr <= re_acc[PW-1:SH];
      pi <= im_acc[PW-1:SH];
    end
  end

endmodule

// File: rtl/butterfly_r2_pipe.sv
// Pipelined radix-2 DIT butterfly: y0 = a + w*b, y1 = a - w*b.
// Three register stages (operands, product, saturated result) under a
// stall-all valid/ready handshake; sticky ovf records any saturation.
// Build macro BUTTERFLY_ROUND_EN: product and scale shifts round half-up
// instead of flooring; latency is the same either way.
module butterfly_r2_pipe
  import butterfly_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int TW = TW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  butterfly_r2_pipe_if.slave   bus
);

  localparam int XW = W + 2;
  localparam logic signed [XW-1:0] SMAX = XW'(sat_max(W));
  localparam logic signed [XW-1:0] SMIN = XW'(sat_min(W));

  logic en;

  logic                 v1;
  logic                 sc1;
  logic signed [W-1:0]  ar1;
  logic signed [W-1:0]  ai1;
  logic signed [W-1:0]  br1;
  logic signed [W-1:0]  bi1;
  logic signed [TW-1:0] wr1;
  logic signed [TW-1:0] wi1;

  logic                 v2;
  logic                 sc2;
  logic signed [W-1:0]  ar2;
  logic signed [W-1:0]  ai2;
  logic signed [XW-1:0] pr2;
  logic signed [XW-1:0] pi2;

  logic signed [XW-1:0] sum  [4];
  logic signed [XW-1:0] shv  [4];
  logic signed [W-1:0]  ysat [4];
  logic [3:0]           sat;

  // Whole pipe advances together whenever the output slot is free or draining.
  assign en           = bus.out_ready || !bus.out_valid;
  assign bus.in_ready = en;

  // S1: capture operands, twiddle, scale and valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1  <= 1'b0;
      sc1 <= 1'b0;
      ar1 <= '0;
      ai1 <= '0;
      br1 <= '0;
      bi1 <= '0;
      wr1 <= '0;
      wi1 <= '0;
    end else if (en) begin
      v1  <= bus.in_valid;
      sc1 <= bus.scale;
      ar1 <= bus.ar;
      ai1 <= bus.ai;
      br1 <= bus.br;
      bi1 <= bus.bi;
      wr1 <= bus.wr;
      wi1 <= bus.wi;
    end
  end

  cmplx_mult #(
    .W  (W),
    .TW (TW)
  ) u_mult (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .br  (br1),
    .bi  (bi1),
    .wr  (wr1),
    .wi  (wi1),
    .pr  (pr2),
    .pi  (pi2)
  );

  // S2: carry a, scale and valid alongside the registered product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2  <= 1'b0;
      sc2 <= 1'b0;
      ar2 <= '0;
      ai2 <= '0;
    end else if (en) begin
      v2  <= v1;
      sc2 <= sc1;
      ar2 <= ar1;
      ai2 <= ai1;
    end
  end

  // S3 combine: add/sub at W+2 bits, optional halving, then clamp to W bits.
  always_comb begin
    sum[0] = XW'(ar2) + pr2;
    sum[1] = XW'(ai2) + pi2;
    sum[2] = XW'(ar2) - pr2;
    sum[3] = XW'(ai2) - pi2;
    sat    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      shv[i] = sum[i];
      if (sc2) begin
`ifdef BUTTERFLY_ROUND_EN
        shv[i] = (sum[i] + XW'(1)) >>> 1;
`else
        shv[i] = sum[i] >>> 1;
`endif
      end
      ysat[i] = W'(shv[i]);
      if (shv[i] > SMAX) begin
        ysat[i] = SMAX[W-1:0];
        sat[i]  = 1'b1;
      end else if (shv[i] < SMIN) begin
        ysat[i] = SMIN[W-1:0];
        sat[i]  = 1'b1;
      end
    end
  end

  // S3 register: results load only with a real beat, so they hold across bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.y0r       <= '0;
      bus.y0i       <= '0;
      bus.y1r       <= '0;
      bus.y1i       <= '0;
    end else if (en) begin
      bus.out_valid <= v2;
      if (v2) begin
        bus.y0r <= ysat[0];
        bus.y0i <= ysat[1];
        bus.y1r <= ysat[2];
        bus.y1i <= ysat[3];
      end
    end
  end

  // Sticky overflow: a saturating beat entering S3 beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ovf <= 1'b0;
    end else if (en && v2 && (|sat)) begin
      bus.ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      bus.ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Self-checking bench for butterfly_r2_pipe: directed vector table, ovf and
// reset sequences, a backpressure stream and a randomized stream against an
// arithmetic reference model.
module tb_butterfly_r2_pipe;

  localparam int W  = 16;
  localparam int TW = 16;
  localparam longint YMAX = 32767;
  localparam longint YMIN = -32768;

  logic clk;
  logic rst;

  butterfly_r2_pipe_if #(.W(W), .TW(TW)) bus ();

  butterfly_r2_pipe #(.W(W), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ar, ai, br, bi, wr, wi;
    bit sc;
    int y0r, y0i, y1r, y1i;
    bit sat;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vt[9];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Floor division for a positive divisor.
  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, inout bit s);
    if (v > YMAX) begin s = 1; return YMAX; end
    if (v < YMIN) begin s = 1; return YMIN; end
    return v;
  endfunction

  // Reference: complex multiply, renormalise, add/sub, optional halving, clamp.
  function automatic vec_t model(input vec_t v);
    vec_t   o;
    longint p_re, p_im;
    longint s[4];
    bit     st;
    o    = v;
    st   = 0;
    p_re = longint'(v.br) * v.wr - longint'(v.bi) * v.wi;
    p_im = longint'(v.br) * v.wi + longint'(v.bi) * v.wr;
`ifdef BUTTERFLY_ROUND_EN
    p_re = p_re + (longint'(1) << (TW - 2));
    p_im = p_im + (longint'(1) << (TW - 2));
`endif
    p_re = fdiv(p_re, longint'(1) << (TW - 1));
    p_im = fdiv(p_im, longint'(1) << (TW - 1));
    s[0] = v.ar + p_re;
    s[1] = v.ai + p_im;
    s[2] = v.ar - p_re;
    s[3] = v.ai - p_im;
    for (int i = 0; i < 4; i++) begin
      if (v.sc) begin
`ifdef BUTTERFLY_ROUND_EN
        s[i] = fdiv(s[i] + 1, 2);
`else
        s[i] = fdiv(s[i], 2);
`endif
      end
      s[i] = clamp(s[i], st);
    end
    o.y0r = int'(s[0]);
    o.y0i = int'(s[1]);
    o.y1r = int'(s[2]);
    o.y1i = int'(s[3]);
    o.sat = st;
    return o;
  endfunction

  function automatic int pick16();
    case ($urandom_range(0, 5))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.ar = pick16(); v.ai = pick16();
    v.br = pick16(); v.bi = pick16();
    v.wr = pick16(); v.wi = pick16();
    v.sc = 1'($urandom_range(0, 1));
    v.y0r = 0; v.y0i = 0; v.y1r = 0; v.y1i = 0; v.sat = 0;
    return v;
  endfunction

  function automatic vec_t dir_vec(input int k);
    vec_t v;
    v.ar = 100 * k + 7; v.ai = -k;
    v.br = 11 * k;      v.bi = 5;
    v.wr = 16384;       v.wi = -8192;
    v.sc = 1'b0;
    v.y0r = 0; v.y0i = 0; v.y1r = 0; v.y1i = 0; v.sat = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.ar    = W'(v.ar);
    bus.ai    = W'(v.ai);
    bus.br    = W'(v.br);
    bus.bi    = W'(v.bi);
    bus.wr    = TW'(v.wr);
    bus.wi    = TW'(v.wi);
    bus.scale = v.sc;
  endtask

  task automatic chk_y(input string nm, input vec_t e);
    chk({nm, " y0r"}, bus.y0r, e.y0r);
    chk({nm, " y0i"}, bus.y0i, e.y0i);
    chk({nm, " y1r"}, bus.y1r, e.y1r);
    chk({nm, " y1i"}, bus.y1i, e.y1i);
  endtask

  task automatic pulse_clr();
    @(negedge clk); bus.ovf_clr = 1'b1;
    @(negedge clk); bus.ovf_clr = 1'b0;
  endtask

  // Single beat with free output; checks latency, data, ovf and one-cycle valid.
  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    pulse_clr();
    @(negedge clk);
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({nm, " in_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, 3);
    chk_y(nm, v);
    chk({nm, " ovf"}, bus.ovf, v.sat);
    @(posedge clk); #1;
    chk({nm, " valid one cycle"}, bus.out_valid, 0);
  endtask

  // Streams n beats through a scoreboard. rnd=0: fixed 4-cycle stall window.
  task automatic run_stream(input int n, input bit rnd, input string tag);
    vec_t q[$];
    vec_t cur, e;
    int   sent, got, cyc;
    bit   have, any_sat;
    int   froz_y0r, froz_y1i;
    sent = 0; got = 0; cyc = 0; have = 0; any_sat = 0;
    froz_y0r = 0; froz_y1i = 0;
    pulse_clr();
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      else     bus.out_ready = !(cyc >= 4 && cyc < 8);
      if (sent < n) begin
        if (!have) begin
          cur  = rnd ? rand_vec() : dir_vec(sent);
          have = 1;
        end
        bus.in_valid = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
        drive(cur);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (!rnd && !bus.out_ready) begin
        chk({tag, " in_ready in stall"}, bus.in_ready, 0);
        chk({tag, " valid in stall"}, bus.out_valid, 1);
        if (cyc == 4) begin
          froz_y0r = bus.y0r;
          froz_y1i = bus.y1i;
        end else begin
          chk({tag, " frozen y0r"}, bus.y0r, froz_y0r);
          chk({tag, " frozen y1i"}, bus.y1i, froz_y1i);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(cur);
        any_sat = any_sat | e.sat;
        q.push_back(e);
        sent++;
        have = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL %s unexpected output beat: got y0r=%0d want none", tag, bus.y0r);
        end else begin
          e = q.pop_front();
          got++;
          chk_y(tag, e);
        end
      end
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk({tag, " beats out"}, got, n);
    chk({tag, " beats pending"}, q.size(), 0);
    chk({tag, " ovf"}, bus.ovf, any_sat);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1000, 200, 300, -50, -32768, 0, 0, 700, 250, 1300, 150, 0};
    vt[1] = '{1000, 200, 300, -50, 0, -32768, 0, 950, -100, 1050, 500, 0};
    vt[2] = '{1000, 200, 300, -50, 0, -32768, 1, 475, -50, 525, 250, 0};
    vt[3] = '{32767, 0, 32767, 0, -32768, 0, 0, 0, 0, 32767, 0, 1};
    vt[4] = '{0, 0, -32768, 0, -32768, 0, 0, 32767, 0, -32768, 0, 1};
    vt[5] = '{0, 0, -32768, 0, -32768, 0, 1, 16384, 0, -16384, 0, 0};
`ifdef BUTTERFLY_ROUND_EN
    vt[6] = '{0, 0, 1, 0, 16384, 0, 0, 1, 0, -1, 0, 0};
    vt[7] = '{0, 0, -1, 0, 16384, 0, 0, 0, 0, 0, 0, 0};
    vt[8] = '{3, -3, 0, 0, 0, 0, 1, 2, -1, 2, -1, 0};
`else
    vt[6] = '{0, 0, 1, 0, 16384, 0, 0, 0, 0, 0, 0, 0};
    vt[7] = '{0, 0, -1, 0, 16384, 0, 0, -1, 0, 1, 0, 0};
    vt[8] = '{3, -3, 0, 0, 0, 0, 1, 1, -2, 1, -2, 0};
`endif

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.ovf_clr = 1'b0;
    drive(vt[0]);
    rst = 1'b1;
    #1 rst = 1'b0;
    #20;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset y0r", bus.y0r, 0);
    chk("reset y1i", bus.y1i, 0);
    chk("reset ovf", bus.ovf, 0);
    @(negedge clk); rst = 1'b1;
    #1 chk("idle in_ready", bus.in_ready, 1);

    for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Sticky ovf: hold, clear, and clear losing to a coincident saturation.
    run_vec(vt[3], "sat");
    repeat (3) @(posedge clk);
    #1 chk("ovf held", bus.ovf, 1);
    @(negedge clk); bus.ovf_clr = 1'b1;
    @(posedge clk); #1 chk("ovf cleared", bus.ovf, 0);
    bus.ovf_clr = 1'b0;
    @(negedge clk); drive(vt[3]); bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); bus.ovf_clr = 1'b1;
    @(posedge clk); #1;
    chk("coincident valid", bus.out_valid, 1);
    chk("coincident ovf", bus.ovf, 1);
    bus.ovf_clr = 1'b0;

    run_stream(6, 1'b0, "stall");
    run_stream(300, 1'b1, "rand");

    // Reset in the middle of a stalled, saturated stream.
    pulse_clr();
    @(negedge clk);
    drive(vt[3]);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1 drive(vt[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("pre-reset valid", bus.out_valid, 1);
    chk("pre-reset ovf", bus.ovf, 1);
    #2 rst = 1'b0;
    #1;
    chk("async reset valid", bus.out_valid, 0);
    chk("async reset y0r", bus.y0r, 0);
    chk("async reset y0i", bus.y0i, 0);
    chk("async reset y1r", bus.y1r, 0);
    chk("async reset y1i", bus.y1i, 0);
    chk("async reset ovf", bus.ovf, 0);
    bus.in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1 chk("post-reset in_ready", bus.in_ready, 1);
    repeat (4) @(posedge clk);
    #1 chk("flushed valid", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/butterfly_r2_pipe.md
Name: butterfly_r2_pipe

Overview:
- Parametrised, pipelined radix-2 DIT complex butterfly for the FFT datapath.
- Computes y0 = a + w·b and y1 = a − w·b with a full complex twiddle multiply.
- Supports optional per-transform ÷2 scaling, saturation with a sticky overflow flag, and a valid/ready stall-all handshake.
- One instance per FFT stage; it replaces the fixed trivial-twiddle butterfly.

Parameters:
- W, 16: data width per real/imag component, two's complement.
- TW, 16: twiddle width per component, signed Q1.(TW−1); +1.0 is not representable, −1.0 is.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- ar, ai  in  W  operand a (real, imag).
- br, bi  in  W  operand b.
- wr, wi  in  TW  twiddle w.
- scale  in  1  1 = outputs arithmetic-shifted right by 1; sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- y0r, y0i, y1r, y1i  out  W  results.
- ovf  out  1  sticky saturation flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (rst=0, async): all stage valid bits, all data registers and ovf clear to 0. in_ready = 1 once rst=1, since the pipe is empty.
- Handshake (stall-all):
  - en = out_ready || !out_valid.
  - in_ready = en.
  - All stages advance only when en=1.
  - Bubbles propagate as valid=0.
  - While en=0, every register and output holds stable.
- Latency: 3 cycles, from the accepting edge to out_valid=1. Throughput is 1 beat/cycle when out_ready=1.
- S1: register a, b, w, scale and valid.
- S2 (multiply):
  - pr = br·wr − bi·wi and pi = br·wi + bi·wr, each computed at full precision (W+TW+1 bits).
  - Arithmetic shift right by TW−1 to W+2 bits; truncation, i.e. floor.
  - Register alongside a, scale and valid.
- S3 (combine):
  - s0 = a + p and s1 = a − p, at W+2 bits.
  - If scale=1, arithmetic shift right by 1 (floor).
  - Saturate each component to [−2^(W−1), 2^(W−1)−1].
  - Register the outputs and out_valid.
- ovf:
  - Set when any component of a valid S3 beat saturates.
  - Cleared by ovf_clr=1 on the same edge only if no new saturation occurs; a new saturation wins and ovf stays 1.
  - Saturation is not evaluated on bubbles.
- Boundaries:
  - b = (−2^(W−1)) with w = −1.0 must produce +2^(W−1) internally, with no wrap; the W+2 intermediate guarantees this.
  - Reset asserted mid-stream discards in-flight beats; out_valid drops to 0 asynchronously.
  - Output data holds its last value while out_valid=0 and is don't-care for checking.

Optional Feature:
- Macro BUTTERFLY_ROUND_EN.
- Defined:
  - Product shift rounds half-up: add 2^(TW−2) before the shift.
  - scale shift adds 1 before >>1.
  - Saturation is applied after rounding.
- Undefined: both shifts truncate (floor). Latency is unchanged in both builds.

Decomposition:
- Package butterfly_pkg holds:
  - default W/TW constants;
  - SAT_MAX/SAT_MIN functions of W;
  - the Q-format shift constant TW−1;
  - the rounding-constant function.
- One sub-module, cmplx_mult: S2's registered 4-multiplier complex product with shift/round. It takes en and is instantiated once.
- Saturation and the add/sub stay inline.

Test Plan:
- Reset/idle: rst=0 mid-traffic → out_valid=0, all y*=0, ovf=0 immediately. After release, in_ready=1.
- Inputs a=(1000,200), b=(300,−50), w=(0x8000,0) i.e. −1.0, scale=0 → after 3 cycles y0=(700,250), y1=(1300,150), out_valid for exactly 1 cycle.
- Same a and b, w=(0,0x8000) i.e. −j:
  - scale=0 → y0=(950,−100), y1=(1050,500).
  - scale=1 → y0=(475,−50), y1=(525,250).
- Inputs a=(32767,0), b=(32767,0), w=(0x8000,0):
  - Result → y0=(0,0), y1=(32767,0) saturated, ovf=1 and held.
  - ovf_clr pulse → ovf=0.
  - ovf_clr coincident with another saturating beat → ovf stays 1.
- Backpressure: stream 6 beats with distinct a values, out_ready=0 for 4 cycles mid-stream → in_ready=0 during the stall, outputs frozen, all 6 results in order with no duplicates or drops.
- Rounding: a=0, w=(0x4000,0), scale=0:
  - b=(1,0) → y0r=1 with BUTTERFLY_ROUND_EN, 0 without.
  - b=(−1,0) → y0r=0 with BUTTERFLY_ROUND_EN, −1 without.
